program_loader: RTL

- Writer side of the instruction memory: receives a framed byte stream, assembles 16-bit instruction words, and writes them into program memory starting at address 0.
- The fetch path is the reader; this block holds the core stalled while loading and pulses a restart when done.
- Sits between an external byte source (UART receiver or test host) and the program memory write port.

---
 rtl/program_loader_pkg.sv | 42 ++++
 rtl/program_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
//
// Purpose: shared definitions for the program loader: the loader FSM state
//          encoding, the default frame start marker and a helper that turns
//          the LEN byte of a frame into a word count.
//
// Contents:
//   state_e            - loader FSM states
//   SYNC_BYTE_DEFAULT  - default frame start marker (8'hA5)
//   COUNT_WIDTH        - width of the word counter (must hold 256)
//   decode_len()       - LEN byte to word count, 0 meaning 256
// -----------------------------------------------------------------------------
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // One bit wider than a byte so that a LEN of 0 can be stored as 256.
    localparam int COUNT_WIDTH = 9;

    // LEN is a word count where 0 stands for 256 words.
    function automatic logic [COUNT_WIDTH-1:0] decode_len(input logic [7:0] len_byte);
        logic [COUNT_WIDTH-1:0] count;
        if (len_byte == 8'd0) begin
            count = 9'd256;
        end else begin
            count = {1'b0, len_byte};
        end
        return count;
    endfunction

endpackage

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose: writer side of the instruction memory. Receives a framed byte
//          stream (SYNC, LEN, LEN words high byte first, optional CHK),
//          assembles 16-bit instruction words and writes them into program
//          memory starting at address 0. Holds the core stalled while a frame
//          is being loaded and pulses o_done when a good frame completes so the
//          core can restart from PC 0.
//
// Build option:
//   PROGRAM_LOADER_CHECKSUM_EN - when defined, every frame ends with a CHK
//          byte (XOR of all data bytes). A mismatch sets the sticky o_error
//          and leaves the core held. When undefined, there is no CHK byte,
//          the frame ends after the last write, and o_error is tied to 0.
//
// Parameters:
//   ADDR_WIDTH - instruction address width (matches the core)
//   SYNC_BYTE  - frame start marker
//
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst        - asynchronous active-high reset
//   i_byte       - incoming stream byte
//   i_byte_valid - i_byte is valid this cycle
//   o_byte_ready - loader accepts i_byte this cycle
//   o_wr_en      - one-cycle program memory write strobe
//   o_wr_addr    - program memory write address
//   o_wr_data    - instruction word to write
//   o_core_hold  - stall core and PC while high
//   o_done       - one-cycle pulse after a good frame
//   o_error      - sticky frame error flag
// -----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [15:0]           o_wr_data,
    output logic                  o_core_hold,
    output logic                  o_done,
    output logic                  o_error
);

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [15:0]              data_q, data_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     hold_q, hold_d;
    logic                     byte_ready;
    logic                     byte_accept;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]               chk_q, chk_d;
    logic                     error_q, error_d;
`endif

    // The loader refuses bytes only while it is busy writing a word or
    // signalling completion; every other state consumes a byte per transfer.
    always_comb begin
        byte_ready  = (state_q != ST_WRITE) && (state_q != ST_DONE);
        byte_accept = i_byte_valid && byte_ready;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        hold_d  = hold_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
        error_d = error_q;
`endif

        case (state_q)
            // Bytes between frames are dropped; only the marker starts a load.
            ST_IDLE: begin
                if (byte_accept && (i_byte == SYNC_BYTE)) begin
                    hold_d  = 1'b1;
                    addr_d  = '0;
                    state_d = ST_LEN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d   = 8'd0;
                    error_d = 1'b0;
`endif
                end
            end

            ST_LEN: begin
                if (byte_accept) begin
                    count_d = decode_len(i_byte);
                    state_d = ST_HI;
                end
            end

            // Inside a frame every byte is data, even one equal to SYNC_BYTE.
            ST_HI: begin
                if (byte_accept) begin
                    data_d  = {i_byte, data_q[7:0]};
                    state_d = ST_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ i_byte;
`endif
                end
            end

            ST_LO: begin
                if (byte_accept) begin
                    data_d  = {data_q[15:8], i_byte};
                    state_d = ST_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ i_byte;
`endif
                end
            end

            // The write strobe uses the current address; the address moves on
            // only afterwards so that the first word lands at 0. Address
            // wrap-around on long frames is intentional and silent.
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                count_d = count_q - COUNT_WIDTH'(1);
                if (count_q == COUNT_WIDTH'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_HI;
                end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            // A corrupt program must not run, so on mismatch the core stays
            // held until a later frame succeeds or reset is applied.
            ST_CHECK: begin
                if (byte_accept) begin
                    if (i_byte == chk_q) begin
                        state_d = ST_DONE;
                        hold_d  = 1'b0;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset aborts any frame in progress and releases the core.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chk_q   <= 8'd0;
            error_q <= 1'b0;
        end else begin
            chk_q   <= chk_d;
            error_q <= error_d;
        end
    end
`endif

    always_comb begin
        o_byte_ready = byte_ready;
        o_wr_en      = (state_q == ST_WRITE);
        o_wr_addr    = addr_q;
        o_wr_data    = data_q;
        o_core_hold  = hold_q;
        o_done       = (state_q == ST_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        o_error      = error_q;
`else
        o_error      = 1'b0;
`endif
    end

endmodule
